piero_collector: RTL
====================

Name: piero_collector

Overview:
- Registered downstream consumer of the piero encoder/decoder stage.
- Samples YA/EA (priority code plus request-valid) and YB/EB (one-hot digit decode plus out-of-range flag) on a strobe.
- Validates each sample, converts the one-hot YB back to a 4-bit digit, and queues {priority, digit} records in a small FIFO drained by a ready/valid consumer.
- Keeps saturating error and drop counters for the system status readout.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 8, width of ERR_CNT and DROP_CNT.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RSTN  input  1  asynchronous active-low reset.
- STB  input  1  sample strobe; YA/EA/YB/EB are captured on edges where STB=1.
- YA  input  2  priority code from the encoder.
- EA  input  1  encoder valid (1 = at least one request).
- YB  input  10  one-hot digit decode.
- EB  input  1  decoder out-of-range flag (1 = input >9, YB expected all zero).
- OUT_RDY  input  1  consumer ready.
- OUT_VLD  output  1  FIFO head valid (FIFO not empty).
- OUT_PRI  output  2  head record priority code.
- OUT_DIG  output  4  head record digit, 0..9.
- FULL  output  1  FIFO occupancy equals DEPTH.
- ERR_CNT  output  CNT_W  count of rejected malformed samples; saturating.
- DROP_CNT  output  CNT_W  count of good records lost because the FIFO was full; saturating.

Behaviour:
- Reset (RSTN=0, asynchronous, any cycle, including mid-operation):
  - Capture register, classify stage, FIFO pointers and both counters clear.
  - OUT_VLD=0, OUT_PRI=0, OUT_DIG=0, FULL=0, ERR_CNT=0, DROP_CNT=0.
  - FIFO contents are don't-care.
  - A strobe in flight at reset is discarded.
- Stage S1 (capture): on an edge with STB=1, register YA, EA, YB and EB, and set S1_VLD. S1_VLD clears on the next edge unless STB is still 1. Back-to-back strobes give one sample per cycle.
- Stage S2 (classify, combinational on S1 regs; action on the next edge):
  - EB=1: if YB is all zero, ERR_CNT+1 with no push. If YB is nonzero, also ERR_CNT+1 (only one increment per sample).
  - EB=0 and YB not exactly one-hot (zero or multiple bits): ERR_CNT+1, no push.
  - EB=0, YB one-hot, EA=0: no request; discard silently, no counter change.
  - EB=0, YB one-hot, EA=1: good record. PRI=YA; DIG=index of the set bit (YB[k]=1 -> DIG=k).
- Latency: STB at edge n -> S1 loaded at n -> record in FIFO at edge n+1. OUT_VLD rises after edge n+1 if the FIFO was empty.
- FIFO:
  - Head presented combinationally from storage (first-word-fall-through).
  - Pop on an edge when OUT_VLD=1 and OUT_RDY=1. OUT_RDY while OUT_VLD=0 has no effect.
  - Push on an edge when a good record is present and (not FULL or pop on the same edge).
  - Simultaneous push and pop: occupancy unchanged. Valid at any occupancy, including full (no drop) and empty (impossible: pop needs VLD).
  - Good record while FULL and no pop: record dropped, DROP_CNT+1.
  - Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
  - FULL=1 exactly when occupancy=DEPTH; OUT_VLD=1 exactly when occupancy>0.
- Counters: increment by at most 1 per edge, hold at 2^CNT_W-1, never wrap. Cleared only by reset.
- No other state machine. Control is the S1 valid bit plus FIFO occupancy: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).

Test Plan:
- Reset: assert RSTN=0 mid-stream with 2 entries queued -> all outputs 0 immediately, without waiting for CLK. After release, OUT_VLD stays 0 until a new good sample.
- Good sample: STB one cycle with YA=01, EA=1, YB=0000000010, EB=0 -> two edges later OUT_VLD=1, OUT_PRI=01, OUT_DIG=1. OUT_RDY=1 -> OUT_VLD=0 the next cycle. ERR_CNT=0.
- Rejects:
  - YA=11, EA=1, YB=0, EB=1 -> ERR_CNT=1, no push.
  - YB=0000000101, EB=0 -> ERR_CNT=2.
  - EA=0, YB=0000000001, EB=0 -> no push, counters unchanged.
- Fill and drop: OUT_RDY=0, 5 consecutive good strobes with digits 0,1,2,3,4 -> FULL=1 after the 4th push, DROP_CNT=1. Draining yields digits 0,1,2,3 in order, then OUT_VLD=0.
- Full plus simultaneous traffic: FIFO full, OUT_RDY=1, good digit 9 arriving the same edge -> no drop, FULL stays 1, head advances; after draining, the last digit out is 9.
- Saturation: force 260 malformed strobes (CNT_W=8) -> ERR_CNT reads 255 and holds.

Source files
------------

// File: rtl/piero_collector_if.sv
// Sample/record bundle between the piero encoder/decoder stage, the collector and its consumer.
// The master drives the samples and consumer ready; the slave (collector) returns the queued records.
interface piero_collector_if #(
  parameter int CNT_W = 8
);
  logic             STB;
  logic [1:0]       YA;
  logic             EA;
  logic [9:0]       YB;
  logic             EB;
  logic             OUT_RDY;
  logic             OUT_VLD;
  logic [1:0]       OUT_PRI;
  logic [3:0]       OUT_DIG;
  logic             FULL;
  logic [CNT_W-1:0] ERR_CNT;
  logic [CNT_W-1:0] DROP_CNT;

  modport master (
    output STB, YA, EA, YB, EB, OUT_RDY,
    input  OUT_VLD, OUT_PRI, OUT_DIG, FULL, ERR_CNT, DROP_CNT
  );

  modport slave (
    input  STB, YA, EA, YB, EB, OUT_RDY,
    output OUT_VLD, OUT_PRI, OUT_DIG, FULL, ERR_CNT, DROP_CNT
  );
endinterface

// File: rtl/piero_collector.sv
// Captures piero encoder/decoder samples, validates them and queues {priority, digit}
// records in a first-word-fall-through FIFO, with saturating error/drop counters.
module piero_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              CLK,
  input  logic              RSTN,
  piero_collector_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  function automatic logic is_onehot(input logic [9:0] v);
    return (v != '0) && ((v & (v - 10'd1)) == '0);
  endfunction

  function automatic logic [3:0] onehot_to_dig(input logic [9:0] v);
    logic [3:0] d;
    d = '0;
    for (int k = 0; k < 10; k++)
      if (v[k]) d = 4'(k);
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Stage 1: capture
  logic       vld_p1;
  logic [1:0] ya_p1;
  logic       ea_p1;
  logic [9:0] yb_p1;
  logic       eb_p1;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vld_p1 <= 1'b0;
      ya_p1  <= '0;
      ea_p1  <= 1'b0;
      yb_p1  <= '0;
      eb_p1  <= 1'b0;
    end else begin
      vld_p1 <= bus.STB;
      if (bus.STB) begin
        ya_p1 <= bus.YA;
        ea_p1 <= bus.EA;
        yb_p1 <= bus.YB;
        eb_p1 <= bus.EB;
      end
    end
  end

  // Stage 2: classify, then push / count on the next edge
  logic       onehot_p1;
  logic       err_p1;
  logic       good_p1;
  logic [5:0] rec_p1;

  assign onehot_p1 = is_onehot(yb_p1);
  assign err_p1    = vld_p1 && (eb_p1 || !onehot_p1);
  assign good_p1   = vld_p1 && !eb_p1 && onehot_p1 && ea_p1;
  assign rec_p1    = {ya_p1, onehot_to_dig(yb_p1)};

  logic [5:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, nonempty, push, pop, drop;

  assign full     = (count == DEPTH_C);
  assign nonempty = (count != '0);
  assign pop      = nonempty && bus.OUT_RDY;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the record.
  assign push     = good_p1 && (!full || pop);
  assign drop     = good_p1 && full && !pop;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= rec_p1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  logic [CNT_W-1:0] err_cnt, drop_cnt;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (err_p1) err_cnt  <= sat_inc(err_cnt);
      if (drop)   drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // Head is gated so that an empty FIFO presents zeros rather than stale storage.
  assign bus.OUT_VLD  = nonempty;
  assign bus.OUT_PRI  = nonempty ? mem[rd_ptr][5:4] : 2'b00;
  assign bus.OUT_DIG  = nonempty ? mem[rd_ptr][3:0] : 4'd0;
  assign bus.FULL     = full;
  assign bus.ERR_CNT  = err_cnt;
  assign bus.DROP_CNT = drop_cnt;
endmodule
